// File: rtl/core_pkg.sv
// Shared core types and constants for the fetch stage.
package core_pkg;

    localparam int              XLEN       = 32;
    localparam logic [XLEN-1:0] NOP_INSN   = 32'h0000_0000;
    localparam int              INSN_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
        logic            filled;
    } fetch_slot_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(INSN_BYTES - 1));
    endfunction

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order slot queue between instruction-memory responses and the IF/ID register.
// Slots are allocated at request grant and filled in order as responses return.
module fetch_slot_queue
    import core_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              alloc,
    input  logic [XLEN-1:0]   alloc_pc,
    input  logic              fill,
    input  logic [XLEN-1:0]   fill_ins,
    input  logic              pop,
    input  logic              flush,
    output fetch_slot_t       head,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  unfilled
);

    fetch_slot_t      slots_q [QDEPTH];
    fetch_slot_t      slots_d [QDEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] n_filled;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        slots_d = slots_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fill_d  = fill_q;
        count_d = count_q;
        if (flush) begin
            for (int i = 0; i < QDEPTH; i++) slots_d[i].filled = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            fill_d  = '0;
            count_d = '0;
        end else begin
            // A fill always targets an allocated-unfilled slot, so it never collides with the popped head.
            if (fill) begin
                slots_d[fill_q].ins    = fill_ins;
                slots_d[fill_q].filled = 1'b1;
                fill_d                 = ptr_inc(fill_q);
            end
            if (pop) begin
                slots_d[head_q].filled = 1'b0;
                head_d                 = ptr_inc(head_q);
            end
            if (alloc) begin
                slots_d[tail_q].pc     = alloc_pc;
                slots_d[tail_q].filled = 1'b0;
                tail_d                 = ptr_inc(tail_q);
            end
            case ({alloc, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: blocking '=' accumulates inside combinational logic; state below uses non-blocking '<=' only.
    always_comb begin
        n_filled = '0;
        for (int i = 0; i < QDEPTH; i++) n_filled = n_filled + CNT_W'(slots_q[i].filled);
    end

    // NOTE: only the filled bits are reset; pc/ins payload is always qualified by filled.
    always_ff @(posedge CLK) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) slots_q[i].filled <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            slots_q <= slots_d;
        end
    end

    assign head     = slots_q[head_q];
    assign count    = count_q;
    assign unfilled = count_q - n_filled;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests and presents insF/PCF/PCPlus4F.
// Define FETCH_PERF_EN to add the fetched_cnt/killed_cnt performance counters.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              stallF,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   insF,
    output logic [XLEN-1:0]   PCF,
    output logic [XLEN-1:0]   PCPlus4F,
    output logic              validF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetched_cnt,
    output logic [31:0]       killed_cnt
`endif
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [XLEN-1:0]  pc_req_q, pc_req_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    fetch_slot_t      head;
    logic [CNT_W-1:0] count, unfilled;
    logic             alloc, fill, pop, drop;

    fetch_slot_queue #(.QDEPTH(QDEPTH)) u_queue (
        .CLK      (CLK),
        .reset    (reset),
        .alloc    (alloc),
        .alloc_pc (pc_req_q),
        .fill     (fill),
        .fill_ins (imem_rdata),
        .pop      (pop),
        .flush    (redirect),
        .head     (head),
        .count    (count),
        .unfilled (unfilled)
    );

    // Killed responses still occupy memory bandwidth, so they count against the in-flight bound.
    assign imem_req  = !reset && !redirect &&
                       (({1'b0, count} + {1'b0, drop_cnt_q}) < (CNT_W + 1)'(QDEPTH));
    assign imem_addr = pc_req_q;

    assign validF   = !reset && (count != '0) && head.filled;
    assign insF     = validF ? head.ins : NOP_INSN;
    assign PCF      = validF ? head.pc : '0;
    assign PCPlus4F = validF ? head.pc + XLEN'(INSN_BYTES) : '0;

    assign alloc = imem_req && imem_gnt;
    assign drop  = imem_rvalid && (drop_cnt_q != '0);
    assign fill  = imem_rvalid && (drop_cnt_q == '0) && !redirect && !reset;
    assign pop   = validF && !stallF && !redirect;

    always_comb begin
        pc_req_d   = pc_req_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            // Every wrong-path request not yet answered must be swallowed when it returns.
            pc_req_d   = align_pc(redirect_pc);
            drop_cnt_d = drop_cnt_q + unfilled - CNT_W'(imem_rvalid);
        end else begin
            if (alloc) pc_req_d = pc_req_q + XLEN'(INSN_BYTES);
            if (drop)  drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pc_req_q   <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_req_q   <= pc_req_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_cnt_q, fetched_cnt_d;
    logic [31:0] killed_cnt_q, killed_cnt_d;

    always_comb begin
        fetched_cnt_d = fetched_cnt_q + 32'(pop);
        if (redirect)
            killed_cnt_d = killed_cnt_q + 32'(count - unfilled) + 32'(imem_rvalid);
        else
            killed_cnt_d = killed_cnt_q + 32'(drop);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            fetched_cnt_q <= '0;
            killed_cnt_q  <= '0;
        end else begin
            fetched_cnt_q <= fetched_cnt_d;
            killed_cnt_q  <= killed_cnt_d;
        end
    end

    assign fetched_cnt = fetched_cnt_q;
    assign killed_cnt  = killed_cnt_q;
`endif

    a_no_orphan_rsp: assert property (@(posedge CLK) disable iff (reset)
        imem_rvalid |-> ((drop_cnt_q != '0) || (unfilled != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed scenarios and random traffic.
module tb_fetch_unit;

    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

    typedef struct { logic [31:0] pc; logic [31:0] ins; bit have; } ent_t;
    typedef struct { logic [31:0] addr; int ready; } mreq_t;

    logic        CLK = 1'b0;
    logic        reset, stallF, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] insF, PCF, PCPlus4F;
    logic        validF;

    logic        w_req, w_rvalid, w_validF;
    logic [31:0] w_addr, w_rdata, w_insF, w_PCF, w_PCPlus4F;
`ifdef FETCH_PERF_EN
    logic [31:0] fetched_cnt, killed_cnt, w_fetched_cnt, w_killed_cnt;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) u_dut (
        .CLK(CLK), .reset(reset), .stallF(stallF), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .insF(insF), .PCF(PCF), .PCPlus4F(PCPlus4F), .validF(validF)
`ifdef FETCH_PERF_EN
        , .fetched_cnt(fetched_cnt), .killed_cnt(killed_cnt)
`endif
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .QDEPTH(QDEPTH)) u_dut_wrap (
        .CLK(CLK), .reset(reset), .stallF(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .insF(w_insF), .PCF(w_PCF), .PCPlus4F(w_PCPlus4F), .validF(w_validF)
`ifdef FETCH_PERF_EN
        , .fetched_cnt(w_fetched_cnt), .killed_cnt(w_killed_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc = 0, since_rst = 0, first_valid_at = -1;
    int g_gnt_pct = 100, g_lat_min = 1, g_lat_max = 1;
    bit g_wrap_chk = 0;
    bit last_req, last_valid;
    logic [31:0] last_addr, last_pcf, last_ins;

    ent_t        mq[$];
    int          drops = 0;
    logic [31:0] mpc = RESET_PC;
    mreq_t       memq[$];
    int          last_ready = 0;
    bit          w_pend_v = 0;
    logic [31:0] w_pend_a = '0;

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model and memory.
    task automatic cycle(input bit rst, input bit stl, input bit rdr, input logic [31:0] rpc);
        bit    exp_req, exp_valid, pop;
        int    unf, lat, r, idx;
        mreq_t m;
        ent_t  e;
        reset       = rst;
        stallF      = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        imem_gnt    = ($urandom_range(99) < g_gnt_pct);
        if (!rst && memq.size() > 0 && memq[0].ready <= cyc) begin
            m           = memq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = ins_of(m.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        w_rvalid = !rst && w_pend_v;
        w_rdata  = ins_of(w_pend_a);
        #1;

        exp_req   = !rst && !rdr && (mq.size() + drops < QDEPTH);
        exp_valid = !rst && mq.size() > 0 && mq[0].have;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, mpc);
        check("validF", 32'(validF), 32'(exp_valid));
        check("insF", insF, exp_valid ? mq[0].ins : 32'h0);
        check("PCF", PCF, exp_valid ? mq[0].pc : 32'h0);
        check("PCPlus4F", PCPlus4F, exp_valid ? mq[0].pc + 32'd4 : 32'h0);

        if (g_wrap_chk && !rst) begin
            case (since_rst)
                0: check("wrap_addr0", w_addr, WRAP_PC);
                1: check("wrap_addr1", w_addr, 32'h0000_0000);
                2: begin
                    check("wrap_validF", 32'(w_validF), 32'd1);
                    check("wrap_PCF", w_PCF, WRAP_PC);
                    check("wrap_PCPlus4F", w_PCPlus4F, 32'h0000_0000);
                end
                default: ;
            endcase
        end

        last_req   = imem_req;
        last_addr  = imem_addr;
        last_valid = validF;
        last_pcf   = PCF;
        last_ins   = insF;
        if (!rst && validF && first_valid_at < 0) first_valid_at = since_rst;

        if (rst) begin
            memq.delete();
            last_ready = cyc;
        end else if (imem_req && imem_gnt) begin
            lat = $urandom_range(g_lat_max, g_lat_min);
            r   = cyc + lat;
            if (r <= last_ready) r = last_ready + 1;
            memq.push_back('{addr: imem_addr, ready: r});
            last_ready = r;
        end
        w_pend_v = !rst && w_req;
        w_pend_a = w_addr;

        if (rst) begin
            mq.delete();
            drops = 0;
            mpc   = RESET_PC;
        end else if (rdr) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].have) unf++;
            drops = drops + unf - int'(imem_rvalid);
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            pop = exp_valid && !stl;
            if (imem_rvalid) begin
                if (drops > 0) drops--;
                else begin
                    idx = -1;
                    foreach (mq[i]) if (idx < 0 && !mq[i].have) idx = i;
                    if (idx >= 0) begin
                        e = mq[idx];
                        e.ins = imem_rdata;
                        e.have = 1;
                        mq[idx] = e;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (exp_req && imem_gnt) begin
                mq.push_back('{pc: mpc, ins: 32'h0, have: 0});
                mpc = mpc + 32'd4;
            end
        end

        if (rst) begin
            since_rst      = 0;
            first_valid_at = -1;
        end else since_rst++;
        cyc++;
        @(negedge CLK);
    endtask

    initial begin
        bit          stall_done, hit, found_a, found_v, stl;
        int          stall_left;
        logic [31:0] nxt, first_addr, first_pc;
        reset = 1'b1; stallF = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        w_rvalid = 1'b0; w_rdata = '0;
        @(negedge CLK);

        // Reset, zero-wait streaming, a 3-cycle stall at PC 0x104, and the wrap instance.
        g_wrap_chk = 1;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        stall_left = 0; stall_done = 0; nxt = RESET_PC;
        for (int i = 0; i < 30; i++) begin
            if (!stall_done && mq.size() > 0 && mq[0].have && mq[0].pc == 32'h104) begin
                stall_left = 3;
                stall_done = 1;
            end
            stl = (stall_left > 0);
            cycle(0, stl, 0, 0);
            if (stall_left > 0) stall_left--;
            if (last_valid && !stl) begin
                check("stream_pc", last_pcf, nxt);
                check("stream_ins", last_ins, ins_of(nxt));
                nxt = nxt + 32'd4;
            end
        end
        g_wrap_chk = 0;
        check("first_valid_cyc", 32'(first_valid_at), 32'd2);
        check("stall_seen", 32'(stall_done), 32'd1);

        // Redirect with two requests in flight and a 3-cycle memory.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        g_lat_min = 3; g_lat_max = 3;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (mq.size() == 2 && drops == 0 && !mq[0].have && !mq[1].have) begin
                cycle(0, 0, 1, 32'h2003);
                hit = 1;
            end else cycle(0, 0, 0, 0);
        end
        check("redir2_setup", 32'(hit), 32'd1);
        found_a = 0; found_v = 0; first_addr = 32'hDEAD_BEEF; first_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 0);
            if (last_req && !found_a) begin first_addr = last_addr; found_a = 1; end
            if (last_valid && !found_v) begin first_pc = last_pcf; found_v = 1; end
        end
        check("redir2_first_addr", first_addr, 32'h2000);
        check("redir2_first_pcf", first_pc, 32'h2000);

        // Redirect while stalled, with a response arriving in the same cycle.
        cycle(1, 0, 0, 0);
        g_lat_min = 2; g_lat_max = 2;
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (mq.size() > 0 && mq[0].have && memq.size() > 0 && memq[0].ready <= cyc) begin
                cycle(0, 1, 1, 32'h3000);
                hit = 1;
            end else cycle(0, 0, 0, 0);
        end
        check("rdr_stall_setup", 32'(hit), 32'd1);
        cycle(0, 0, 0, 0);
        check("rdr_stall_validF", 32'(last_valid), 32'd0);
        check("rdr_stall_insF", last_ins, 32'h0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);

        // Random traffic: variable grant, latency, stalls, redirects and occasional resets.
        g_gnt_pct = 70; g_lat_min = 1; g_lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) cycle(1, 0, 0, 0);
            else cycle(0, $urandom_range(99) < 30, $urandom_range(99) < 5, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
